tmcu_sram_ctrl: RTL and testbench
=================================

// Module: tmcu_sram_ctrl
// PURPOSE
//  Initiator-side controller for the single-port tmcu SRAM: accepts valid/ready word requests from the core
//  bus and drives the SRAM addr/wdata/write/read port. The SRAM has one-cycle registered read data and no byte
//  strobes, so partial writes are done as read-modify-write. Sits between the bus fabric and the 4KB SRAM.
// PARAMETERS
//  BASE_ADDR  32'h2000_0000  byte base of the SRAM window; must be aligned to 2**ADDR_W
//  ADDR_W     12             byte-address width of the window (12 = 4KB)
// PORTS
//  clk         in   1   clock; everything is on the rising edge
//  rst_n       in   1   asynchronous active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   controller can accept; transfer happens when req_valid&&req_ready
//  req_write   in   1   1=write, 0=read
//  req_addr    in   32  byte address
//  req_wdata   in   32  write data
//  req_be      in   4   byte enables, bit i = byte i; ignored on reads
//  rsp_valid   out  1   one-cycle response pulse; there is no rsp backpressure
//  rsp_rdata   out  32  read data, valid with rsp_valid on reads; 0 otherwise
//  rsp_err     out  1   with rsp_valid: request rejected, no SRAM access done
//  sram_addr   out  32  to SRAM addr = {(32-ADDR_W)'0, captured req_addr[ADDR_W-1:0]}
//  sram_wdata  out  32  to SRAM wdata
//  sram_write  out  1   to SRAM write
//  sram_read   out  1   to SRAM read
//  sram_rdata  in   32  from SRAM rdata; valid the cycle after sram_read
// BEHAVIOUR
//  - Reset (async assert) puts the FSM in IDLE and clears the capture regs. Outputs: req_ready=1; rsp_valid,
//    rsp_err, sram_write, sram_read=0; rsp_rdata, sram_wdata, sram_addr=0.
//  - req_ready=1 only in IDLE. On acceptance, write/addr/wdata/be are captured. sram_* and rsp_* decode only from
//    state and capture regs. There is no combinational path from req_* to any output.
//  - Decode at accept: err if req_addr[31:ADDR_W]!=BASE_ADDR[31:ADDR_W] or req_addr[1:0]!=0.
//  - FSM states: IDLE, RD, RD_RSP, WR, RMW_RD, RMW_WR, NOP_RSP, ERR_RSP. Accept at cycle T goes to:
//      err                   -> ERR_RSP
//      read                  -> RD
//      write, be==4'hF       -> WR
//      write, be==0          -> NOP_RSP
//      write, other be       -> RMW_RD
//  - RD (T+1): sram_read=1 -> RD_RSP.
//    RD_RSP (T+2): rsp_valid=1, rsp_rdata=sram_rdata -> IDLE.
//  - WR (T+1): sram_write=1, sram_wdata=wdata, rsp_valid=1 -> IDLE.
//  - RMW_RD (T+1): sram_read=1 -> RMW_WR.
//    RMW_WR (T+2): sram_write=1, sram_wdata byte i = be[i] ? wdata byte i : sram_rdata byte i; rsp_valid=1 -> IDLE.
//  - NOP_RSP (T+1): rsp_valid=1, no SRAM access -> IDLE.
//    ERR_RSP (T+1): rsp_valid=1, rsp_err=1, no SRAM access -> IDLE.
//  - Latency accept->rsp: read 2 cycles, full/no-op write 1, partial write 2, error 1.
//    The next accept can happen in the cycle after rsp_valid.
//  - sram_read and sram_write are never both 1. Each is high for exactly one cycle per access.
//  - rsp_err=0 and rsp_rdata=0 whenever rsp_valid=0, and on write responses.
//  - Reset mid-operation aborts the access: no pending rsp_valid, and no sram_write unless reset falls after
//    that cycle's edge. SRAM contents are not touched by reset.
//  - Top-of-window address (offset ADDR_W'hFFC) is legal. Offset wrap past the window is an error,
//    not an alias.
// TESTING
//  1. Write 0xDEADBEEF be=F to 0x2000_0010, then read it -> sram_write@T+1, rsp@T+1; read rsp@T+2 rdata=0xDEADBEEF.
//  2. Word=0x11223344, write 0xAABBCCDD be=4'b0101 -> RMW read then write 0x11BB33DD, rsp@T+2; readback 0x11BB33DD.
//  3. Read 0x2000_1000 (out of window) and 0x2000_0002 (misaligned) -> rsp_err=1@T+1, sram_read/write never high.
//  4. Write be=0 to a word holding 0x5A5A5A5A -> rsp@T+1, no SRAM strobe; readback 0x5A5A5A5A.
//  5. Back-to-back req_valid held high for 4 reads -> req_ready low between accepts, 4 rsps in order, 3 cycles each.
//  6. rst_n low during RMW_RD -> next cycle rsp_valid=0, sram_write=0, req_ready=1; the word is unchanged on readback.

Source files
------------

// File: rtl/tmcu_sram_ctrl.sv
// Bus-side controller for the single-port tmcu SRAM: turns valid/ready word requests into SRAM
// strobes, and turns partial-byte writes into a read-modify-write.
module tmcu_sram_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int          ADDR_W    = 12
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_be,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [31:0] o_sram_addr,
  output logic [31:0] o_sram_wdata,
  output logic        o_sram_write,
  output logic        o_sram_read,
  input  logic [31:0] i_sram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_RSP,
    WR,
    RMW_RD,
    RMW_WR,
    NOP_RSP,
    ERR_RSP
  } state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_be;
  logic                w_accept;
  logic                w_err;
  logic [31:0]         w_mergedData;

  // Out-of-window offsets are rejected rather than aliased back into the SRAM.
  assign w_err    = (i_req_addr[31:ADDR_W] != BASE_ADDR[31:ADDR_W]) || (i_req_addr[1:0] != 2'b00);
  assign w_accept = i_req_valid && (r_state == IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_accept) begin
      r_addr  <= i_req_addr[ADDR_W-1:0];
      r_wdata <= i_req_wdata;
      r_be    <= i_req_be;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          if (w_err) begin
            w_stateNext = ERR_RSP;
          end else if (!i_req_write) begin
            w_stateNext = RD;
          end else if (i_req_be == 4'hF) begin
            w_stateNext = WR;
          end else if (i_req_be == 4'h0) begin
            w_stateNext = NOP_RSP;
          end else begin
            w_stateNext = RMW_RD;
          end
        end
      end
      RD:      w_stateNext = RD_RSP;
      RMW_RD:  w_stateNext = RMW_WR;
      default: w_stateNext = IDLE;
    endcase
  end

  // Bytes not enabled keep the value just read back from the SRAM.
  always_comb begin
    w_mergedData = i_sram_rdata;
    for (int b = 0; b < 4; b++) begin
      if (r_be[b]) begin
        w_mergedData[8*b +: 8] = r_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    o_req_ready  = 1'b0;
    o_rsp_valid  = 1'b0;
    o_rsp_rdata  = '0;
    o_rsp_err    = 1'b0;
    o_sram_write = 1'b0;
    o_sram_read  = 1'b0;
    o_sram_wdata = '0;
    case (r_state)
      IDLE: o_req_ready = 1'b1;
      RD, RMW_RD: o_sram_read = 1'b1;
      RD_RSP: begin
        o_rsp_valid = 1'b1;
        o_rsp_rdata = i_sram_rdata;
      end
      WR: begin
        o_sram_write = 1'b1;
        o_sram_wdata = r_wdata;
        o_rsp_valid  = 1'b1;
      end
      RMW_WR: begin
        o_sram_write = 1'b1;
        o_sram_wdata = w_mergedData;
        o_rsp_valid  = 1'b1;
      end
      NOP_RSP: o_rsp_valid = 1'b1;
      ERR_RSP: begin
        o_rsp_valid = 1'b1;
        o_rsp_err   = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_sram_addr = {{(32-ADDR_W){1'b0}}, r_addr};

endmodule

// File: tb/tb_tmcu_sram_ctrl.sv
// Self-checking bench for tmcu_sram_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a word-array model of the SRAM window.
module tb_tmcu_sram_ctrl;

  localparam logic [31:0] BASE = 32'h2000_0000;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        expErr;
    logic [31:0] expRdata;
    int          expLat;
    int          expRd;
    int          expWr;
    logic [31:0] expWdata;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_write;
  logic        sram_read;
  logic [31:0] sram_rdata;

  int          testsRun;
  int          testsFailed;
  logic [31:0] sramMem [1024];
  logic [31:0] refMem  [1024];
  vec_t        vecs[$];

  tmcu_sram_ctrl #(.BASE_ADDR(BASE), .ADDR_W(12)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_write  (req_write),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .i_req_be     (req_be),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_err    (rsp_err),
    .o_sram_addr  (sram_addr),
    .o_sram_wdata (sram_wdata),
    .o_sram_write (sram_write),
    .o_sram_read  (sram_read),
    .i_sram_rdata (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro stand-in: registered read data, contents survive reset.
  always @(posedge clk) begin
    if (sram_write) sramMem[sram_addr[11:2]] <= sram_wdata;
    if (sram_read)  sram_rdata <= sramMem[sram_addr[11:2]];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Invariants that must hold every cycle regardless of traffic.
  always @(negedge clk) begin
    checkOutput("rd_wr_exclusive", {31'b0, sram_read & sram_write}, 32'h0);
    if (!rsp_valid) begin
      checkOutput("idle_rsp_err", {31'b0, rsp_err}, 32'h0);
      checkOutput("idle_rsp_rdata", rsp_rdata, 32'h0);
    end
  end

  function automatic vec_t mkVec(logic w, logic [31:0] a, logic [31:0] d, logic [3:0] be, logic err,
                                 logic [31:0] rd, int lat, int nRd, int nWr, logic [31:0] wd);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.be = be; v.expErr = err; v.expRdata = rd;
    v.expLat = lat; v.expRd = nRd; v.expWr = nWr; v.expWdata = wd;
    return v;
  endfunction

  // Expected behaviour straight from the window/latency rules, using the word-array model.
  function automatic vec_t modelTxn(logic w, logic [31:0] a, logic [31:0] d, logic [3:0] be);
    vec_t        v;
    logic [31:0] old;
    logic [31:0] merged;
    v = mkVec(w, a, d, be, 1'b0, 32'h0, 0, 0, 0, 32'h0);
    if (a < BASE || a >= BASE + 32'h1000 || a[1:0] != 2'b00) begin
      v.expErr = 1'b1;
      v.expLat = 1;
      return v;
    end
    old = refMem[int'((a - BASE) / 4)];
    if (!w) begin
      v.expRdata = old; v.expLat = 2; v.expRd = 1;
    end else if (be == 4'h0) begin
      v.expLat = 1;
    end else begin
      merged = old;
      for (int b = 0; b < 4; b++) if (be[b]) merged[8*b +: 8] = d[8*b +: 8];
      v.expWr = 1; v.expWdata = merged;
      v.expLat = (be == 4'hF) ? 1 : 2;
      v.expRd  = (be == 4'hF) ? 0 : 1;
    end
    return v;
  endfunction

  // Entered and left at #1 after a rising edge with the controller idle.
  task automatic applyStimulus(input vec_t v, input string name);
    bit          ready;
    bit          accepted;
    bit          gotRsp;
    int          lat;
    int          rdCnt;
    int          wrCnt;
    logic [31:0] wd;
    logic [31:0] gotErr;
    logic [31:0] gotData;
    req_valid = 1'b1; req_write = v.write; req_addr = v.addr; req_wdata = v.wdata; req_be = v.be;
    accepted = 1'b0;
    for (int w = 0; w < 20; w++) begin
      ready = req_ready;
      @(posedge clk); #1;
      if (ready) begin accepted = 1'b1; break; end
    end
    req_valid = 1'b0; req_write = 1'(($urandom)); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    checkOutput({name, " accepted"}, {31'b0, accepted}, 32'h1);
    if (!accepted) return;
    gotRsp = 1'b0; lat = 0; rdCnt = 0; wrCnt = 0; wd = 32'h0; gotErr = 32'h0; gotData = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      if (sram_read) begin
        rdCnt++;
        checkOutput({name, " rd_addr"}, sram_addr, v.addr & 32'h0000_0FFF);
      end
      if (sram_write) begin
        wrCnt++;
        wd = sram_wdata;
        checkOutput({name, " wr_addr"}, sram_addr, v.addr & 32'h0000_0FFF);
      end
      if (rsp_valid) begin
        gotRsp = 1'b1; lat = c; gotErr = {31'b0, rsp_err}; gotData = rsp_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput({name, " rsp_seen"}, {31'b0, gotRsp}, 32'h1);
    checkOutput({name, " latency"}, lat, v.expLat);
    checkOutput({name, " rsp_err"}, gotErr, {31'b0, v.expErr});
    checkOutput({name, " rsp_rdata"}, gotData, v.expRdata);
    checkOutput({name, " sram_reads"}, rdCnt, v.expRd);
    checkOutput({name, " sram_writes"}, wrCnt, v.expWr);
    if (v.expWr > 0) checkOutput({name, " sram_wdata"}, wd, v.expWdata);
    if (v.write && !v.expErr && v.expWr > 0) refMem[int'((v.addr - BASE) / 4)] = v.expWdata;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] poolAddr(int i);
    return (i < 8) ? BASE + 32'h100 + 32'(i * 4) : BASE + 32'hFE0 + 32'((i - 8) * 4);
  endfunction

  initial begin
    #1_000_000;
    testsFailed++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] b2bAddr [4];
    logic [31:0] b2bData [4];
    logic [31:0] a;
    int          kind;
    testsRun = 0; testsFailed = 0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset req_ready", {31'b0, req_ready}, 32'h1);
    checkOutput("reset rsp_valid", {31'b0, rsp_valid}, 32'h0);
    checkOutput("reset rsp_err", {31'b0, rsp_err}, 32'h0);
    checkOutput("reset sram_write", {31'b0, sram_write}, 32'h0);
    checkOutput("reset sram_read", {31'b0, sram_read}, 32'h0);
    checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset sram_wdata", sram_wdata, 32'h0);
    checkOutput("reset sram_addr", sram_addr, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    vecs.push_back(mkVec(1, 32'h2000_0010, 32'hDEADBEEF, 4'hF, 0, 32'h0,        1, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mkVec(0, 32'h2000_0010, 32'h0,        4'h0, 0, 32'hDEADBEEF, 2, 1, 0, 32'h0));
    vecs.push_back(mkVec(1, 32'h2000_0020, 32'h11223344, 4'hF, 0, 32'h0,        1, 0, 1, 32'h11223344));
    vecs.push_back(mkVec(1, 32'h2000_0020, 32'hAABBCCDD, 4'h5, 0, 32'h0,        2, 1, 1, 32'h11BB33DD));
    vecs.push_back(mkVec(0, 32'h2000_0020, 32'h0,        4'h0, 0, 32'h11BB33DD, 2, 1, 0, 32'h0));
    vecs.push_back(mkVec(0, 32'h2000_1000, 32'h0,        4'hF, 1, 32'h0,        1, 0, 0, 32'h0));
    vecs.push_back(mkVec(0, 32'h2000_0002, 32'h0,        4'hF, 1, 32'h0,        1, 0, 0, 32'h0));
    vecs.push_back(mkVec(1, 32'h2000_0030, 32'h5A5A5A5A, 4'hF, 0, 32'h0,        1, 0, 1, 32'h5A5A5A5A));
    vecs.push_back(mkVec(1, 32'h2000_0030, 32'hFFFFFFFF, 4'h0, 0, 32'h0,        1, 0, 0, 32'h0));
    vecs.push_back(mkVec(0, 32'h2000_0030, 32'h0,        4'h0, 0, 32'h5A5A5A5A, 2, 1, 0, 32'h0));
    vecs.push_back(mkVec(1, 32'h2000_0FFC, 32'h12345678, 4'hF, 0, 32'h0,        1, 0, 1, 32'h12345678));
    vecs.push_back(mkVec(1, 32'h2000_0FFC, 32'hCD000000, 4'h8, 0, 32'h0,        2, 1, 1, 32'hCD345678));
    vecs.push_back(mkVec(0, 32'h2000_0FFC, 32'h0,        4'h0, 0, 32'hCD345678, 2, 1, 0, 32'h0));
    vecs.push_back(mkVec(1, 32'h2000_1000, 32'h0BAD0BAD, 4'hF, 1, 32'h0,        1, 0, 0, 32'h0));
    vecs.push_back(mkVec(1, 32'h1FFF_FFFC, 32'h0BAD0BAD, 4'hF, 1, 32'h0,        1, 0, 0, 32'h0));
    vecs.push_back(mkVec(1, 32'h2000_0001, 32'h0BAD0BAD, 4'hF, 1, 32'h0,        1, 0, 0, 32'h0));
    vecs.push_back(mkVec(0, 32'h0000_0010, 32'h0,        4'h0, 1, 32'h0,        1, 0, 0, 32'h0));
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Four reads with req_valid held: accepts must be exactly three cycles apart.
    b2bAddr[0] = 32'h2000_0010; b2bData[0] = 32'hDEADBEEF;
    b2bAddr[1] = 32'h2000_0020; b2bData[1] = 32'h11BB33DD;
    b2bAddr[2] = 32'h2000_0030; b2bData[2] = 32'h5A5A5A5A;
    b2bAddr[3] = 32'h2000_0FFC; b2bData[3] = 32'hCD345678;
    begin
      int  nAcc;
      int  nRsp;
      int  lastAcc;
      bit  ready;
      nAcc = 0; nRsp = 0; lastAcc = 0;
      req_valid = 1'b1; req_write = 1'b0; req_be = 4'hF; req_addr = b2bAddr[0];
      for (int cyc = 0; cyc < 40 && nRsp < 4; cyc++) begin
        ready = req_ready;
        if (rsp_valid) begin
          checkOutput($sformatf("b2b rdata%0d", nRsp), rsp_rdata, b2bData[nRsp]);
          nRsp++;
        end
        @(posedge clk); #1;
        if (ready && req_valid) begin
          if (nAcc > 0) checkOutput($sformatf("b2b spacing%0d", nAcc), cyc - lastAcc, 3);
          lastAcc = cyc;
          nAcc++;
          if (nAcc < 4) req_addr = b2bAddr[nAcc];
          else req_valid = 1'b0;
        end
      end
      req_valid = 1'b0;
      checkOutput("b2b accepts", nAcc, 4);
      checkOutput("b2b responses", nRsp, 4);
      @(posedge clk); #1;
    end

    // Reset during the read half of a read-modify-write must leave the word intact.
    applyStimulus(mkVec(1, 32'h2000_0040, 32'h01020304, 4'hF, 0, 32'h0, 1, 0, 1, 32'h01020304), "abort_setup");
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h2000_0040; req_wdata = 32'hFFFFFFFF; req_be = 4'h3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("abort rmw_read", {31'b0, sram_read}, 32'h1);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort rsp_valid", {31'b0, rsp_valid}, 32'h0);
    checkOutput("abort sram_write", {31'b0, sram_write}, 32'h0);
    checkOutput("abort req_ready", {31'b0, req_ready}, 32'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(mkVec(0, 32'h2000_0040, 32'h0, 4'h0, 0, 32'h01020304, 2, 1, 0, 32'h0), "abort_readback");

    for (int i = 0; i < 16; i++) applyStimulus(modelTxn(1'b1, poolAddr(i), $urandom, 4'hF), $sformatf("preload%0d", i));
    for (int n = 0; n < 200; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        a = $urandom;
        if (a >= BASE && a < BASE + 32'h1000) a = a ^ 32'h8000_0000;
      end else if (kind == 1) begin
        a = BASE + 32'($urandom_range(0, 1023) * 4) + 32'($urandom_range(1, 3));
      end else begin
        a = poolAddr(int'($urandom_range(0, 15)));
      end
      applyStimulus(modelTxn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom)), $sformatf("rand%0d", n));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
